scan_mux_n: RTL

//   Parametrised, registered N-channel multiplexer with output handshake.

---
 rtl/scan_mux_n.sv | 106 ++++++++++
 1 files changed

// File: rtl/scan_mux_n.sv
// Registered CH:1 mux (manual select or round-robin auto-scan); 1-cycle capture latency; holds sample until out_ready.
// Optional SCAN_MUX_WRAP_PULSE_EN adds a one-cycle wrap flag for the auto capture that returns the scan to channel 0.
module scan_mux_n #(
    parameter  int CH    = 4,
    parameter  int W     = 1,
    parameter  int DWELL = 1,
    localparam int SELW  = $clog2(CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CH*W-1:0]   d,
    input  logic [SELW-1:0]   s,
    input  logic              auto,
    input  logic              en,
    input  logic              out_ready,
    output logic [W-1:0]      z,
    output logic [SELW-1:0]   ch,
    output logic              out_valid,
    output logic              sel_err
`ifdef SCAN_MUX_WRAP_PULSE_EN
   ,output logic              wrap
`endif
);

    localparam int DCW = (DWELL > 1) ? $clog2(DWELL) : 1;

    logic [W-1:0]    z_q, z_d;
    logic [SELW-1:0] ch_q, sel;
    logic            out_valid_q, sel_err_q, auto_q;
    logic [SELW-1:0] scan_ptr_q, scan_ptr_d, ptr_eff;
    logic [DCW-1:0]  dwell_cnt_q, dwell_cnt_d, dwell_eff;
    logic            rise, slot_free, accept, capture, sel_oob, last_dwell, last_ch;

    // Entering auto mode restarts the scan in the same cycle it is used.
    assign rise       = auto && !auto_q;
    assign ptr_eff    = rise ? '0 : scan_ptr_q;
    assign dwell_eff  = rise ? '0 : dwell_cnt_q;
    assign sel        = auto ? ptr_eff : s;
    assign sel_oob    = !auto && (32'(s) >= 32'(CH));
    assign last_dwell = (dwell_eff == DCW'(DWELL - 1));
    assign last_ch    = (ptr_eff == SELW'(CH - 1));

    assign slot_free  = !out_valid_q || out_ready;
    assign accept     = out_valid_q && out_ready;
    assign capture    = en && slot_free;

    // Out-of-range selects match no channel and yield zero.
    always_comb begin
        z_d = '0;
        for (int k = 0; k < CH; k++) begin
            if (sel == SELW'(k)) z_d = d[k*W +: W];
        end
    end

    always_comb begin
        scan_ptr_d  = ptr_eff;
        dwell_cnt_d = dwell_eff;
        if (capture && auto) begin
            if (!last_dwell) begin
                dwell_cnt_d = dwell_eff + DCW'(1);
            end else begin
                dwell_cnt_d = '0;
                scan_ptr_d  = last_ch ? '0 : ptr_eff + SELW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            z_q         <= '0;
            ch_q        <= '0;
            out_valid_q <= 1'b0;
            sel_err_q   <= 1'b0;
            auto_q      <= 1'b0;
            scan_ptr_q  <= '0;
            dwell_cnt_q <= '0;
        end else begin
            auto_q      <= auto;
            scan_ptr_q  <= scan_ptr_d;
            dwell_cnt_q <= dwell_cnt_d;
            if (capture) begin
                z_q         <= z_d;
                ch_q        <= sel;
                out_valid_q <= 1'b1;
                sel_err_q   <= sel_oob;
            end else if (accept) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign z         = z_q;
    assign ch        = ch_q;
    assign out_valid = out_valid_q;
    assign sel_err   = sel_err_q;

`ifdef SCAN_MUX_WRAP_PULSE_EN
    logic wrap_q;
    always_ff @(posedge clk) begin
        if (reset) wrap_q <= 1'b0;
        else       wrap_q <= capture && auto && last_dwell && last_ch;
    end
    assign wrap = wrap_q;
`endif

endmodule
